reaction_timer_core: RTL and testbench

- Reaction-timer engine; sits directly upstream of the display path (digit mux, 7-seg decoder, anode scan).
- Produces four BCD digits of elapsed milliseconds, plus status flags.
- Waits a pseudo-random delay after start, lights the GO LED, then counts ms until the react button is pressed.
- Detects false starts and 9999 ms overflow.

---
 rtl/reaction_pkg.sv | 8 +
 rtl/bcd_counter4.sv | 32 +++
 rtl/reaction_timer_core.sv | 107 ++++++++++
 tb/tb_reaction_timer_core.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and constants for the reaction timer
package reaction_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, GO, DONE, FOUL} state_t;
  typedef logic [3:0] bcd_digit_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] BCD_MAX = 16'h9999;
endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: 4-digit cascaded BCD counter, sync clear, enable, saturates at 9999
//   clk, rst_n (async low) | clr: sync clear | en: count one step
//   value: BCD count [15:12] thousands .. [3:0] units | tc: value == 9999
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] value,
  output logic        tc
);
  logic [15:0] nxt;
  logic inc;
  bcd_digit_t d;
  assign tc = value == BCD_MAX;
  always_comb begin
    nxt = value;
    inc = 1'b1;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d = value[4*i +: 4];
      nxt[4*i +: 4] = inc ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
      inc = inc && d == 4'd9;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (clr) value <= '0;
    else if (en && !tc) value <= nxt;
endmodule

// File: rtl/reaction_timer_core.sv
// reaction_timer_core: random-delay reaction timer producing BCD milliseconds
//   clk, rst_n (async low) | start_btn, react_btn: raw debounced buttons
//   digits: BCD ms | led_go: GO lamp | busy: ARMED or GO | false_start: FOUL | overflow: sticky 9999 ms
//   REACTION_BEST_EN: adds best_ms, the fastest valid BCD time since reset
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic [15:0] digits,
  output logic        led_go,
  output logic        busy,
  output logic        false_start,
  output logic        overflow
`ifdef REACTION_BEST_EN
  ,output logic [15:0] best_ms
`endif
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(MIN_DELAY_MS + 2**RAND_BITS);
  state_t state;
  logic [2:0] start_sr, react_sr;
  logic start_p, react_p;
  logic [15:0] lfsr;
  logic [TW-1:0] cnt;
  logic [DW-1:0] delay;
  logic tick, tc, to_armed, to_foul, to_go, ovf_hit, to_done;
  assign tick     = cnt == TW'(TICK_DIV - 1);
  assign to_armed = start_p && (state == IDLE || state == DONE || state == FOUL);
  assign to_foul  = react_p && state == ARMED;
  // delay is loaded one short, so GO lands exactly on the delay-th tick
  assign to_go    = state == ARMED && !react_p && tick && delay == '0;
  assign ovf_hit  = state == GO && !react_p && tick && tc;
  assign to_done  = state == GO && (react_p || ovf_hit);
  bcd_counter4 u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (to_armed || to_foul),
    .en    (state == GO && tick && !react_p),
    .value (digits),
    .tc    (tc)
  );
  // 2-FF synchronizer plus edge register; pulse is registered so it lands 3 cycles after the raw edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start_sr <= '0;
      react_sr <= '0;
      start_p <= 1'b0;
      react_p <= 1'b0;
      lfsr <= LFSR_SEED;
      cnt <= '0;
    end else begin
      start_sr <= {start_sr[1:0], start_btn};
      react_sr <= {react_sr[1:0], react_btn};
      start_p <= start_sr[1] && !start_sr[2];
      react_p <= react_sr[1] && !react_sr[2];
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      cnt <= (tick || to_armed || to_foul || to_go || to_done) ? '0 : cnt + TW'(1);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      delay <= '0;
      led_go <= 1'b0;
      busy <= 1'b0;
      false_start <= 1'b0;
      overflow <= 1'b0;
    end else if (to_armed) begin
      state <= ARMED;
      delay <= DW'(MIN_DELAY_MS - 1) + DW'(lfsr[RAND_BITS-1:0]);
      busy <= 1'b1;
      false_start <= 1'b0;
      overflow <= 1'b0;
    end else if (to_foul) begin
      state <= FOUL;
      busy <= 1'b0;
      false_start <= 1'b1;
    end else if (to_go) begin
      state <= GO;
      led_go <= 1'b1;
    end else if (to_done) begin
      state <= DONE;
      led_go <= 1'b0;
      busy <= 1'b0;
      overflow <= ovf_hit;
    end else if (state == ARMED && tick) begin
      delay <= delay - DW'(1);
    end
`ifdef REACTION_BEST_EN
  logic done_p;
  // valid BCD orders the same as binary, so a plain compare picks the faster time
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done_p <= 1'b0;
      best_ms <= BCD_MAX;
    end else begin
      done_p <= state == GO && react_p;
      if (done_p && digits < best_ms) best_ms <= digits;
    end
`endif
endmodule

// File: tb/tb_reaction_timer_core.sv
// tb_reaction_timer_core: randomized self-checking bench against a cycle-timed behavioural model
module tb_reaction_timer_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_btn = 1'b0;
  logic react_btn = 1'b0;
  logic [15:0] digits;
  logic led_go, busy, false_start, overflow;
`ifdef REACTION_BEST_EN
  logic [15:0] best_ms;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int best_m = 9999;

  reaction_timer_core #(.TICK_DIV(4), .MIN_DELAY_MS(5), .RAND_BITS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_btn   (start_btn),
    .react_btn   (react_btn),
    .digits      (digits),
    .led_go      (led_go),
    .busy        (busy),
    .false_start (false_start),
    .overflow    (overflow)
`ifdef REACTION_BEST_EN
    ,.best_ms    (best_ms)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = v[0] ? (v >> 1) ^ 16'hB400 : v >> 1;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // edge index at which GO is entered for a start press made when cyc == c
  function automatic int go_edge(input int c);
    logic [15:0] l;
    l = lfsr_at(c + 3);
    return c + 3 + 4 * (5 + int'(l[1:0]));
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(input bit rx, output int c);
    c = cyc;
    if (rx) react_btn = 1'b1;
    else start_btn = 1'b1;
    repeat (3) @(negedge clk);
    react_btn = 1'b0;
    start_btn = 1'b0;
  endtask

  task automatic wait_go(input int g);
    int t;
    t = 0;
    while (!led_go && t < 80) begin
      @(negedge clk);
      t++;
    end
    check("go_time", cyc, g + 1);
    check("go_busy", busy, 1'b1);
    check("go_digits", digits, 16'h0000);
  endtask

  task automatic run_trial(input int ticks, input int off, output logic [15:0] expd);
    int c, g, r, n;
    press(1'b0, c);
    g = go_edge(c);
    wait_go(g);
    r = g + 4 * ticks + off;
    wait_until(r - 3);
    press(1'b1, c);
    n = (r - g - 1) / 4;
    expd = to_bcd(n);
    if (n < best_m) best_m = n;
    wait_until(r + 2);
    check("trial_digits", digits, expd);
    check("trial_led", led_go, 1'b0);
    check("trial_busy", busy, 1'b0);
    check("trial_ovf", overflow, 1'b0);
`ifdef REACTION_BEST_EN
    check("trial_best", best_ms, to_bcd(best_m));
`endif
    repeat ($urandom_range(4, 12)) @(negedge clk);
  endtask

  initial begin
    logic [15:0] e;
    int c, g, seen;
    repeat (3) @(negedge clk);
    check("rst_digits", digits, 16'h0000);
    check("rst_led", led_go, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fs", false_start, 1'b0);
    check("rst_ovf", overflow, 1'b0);
`ifdef REACTION_BEST_EN
    check("rst_best", best_ms, 16'h9999);
`endif
    rst_n = 1'b1;
    repeat ($urandom_range(0, 7)) @(negedge clk);

    run_trial(37, 2, e);
    check("normal_0037", digits, 16'h0037);
    repeat (10) @(negedge clk);
    check("frozen", digits, e);
    press(1'b1, c);
    repeat (6) @(negedge clk);
    check("done_react_ign", digits, e);
    check("done_busy", busy, 1'b0);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 9)) @(negedge clk);
      run_trial($urandom_range(1, 60), $urandom_range(0, 3), e);
    end

    run_trial(100, 0, e);
    check("coincide_0099", digits, 16'h0099);

    press(1'b0, c);
    wait_until(c + 9);
    press(1'b1, c);
    wait_until(c + 5);
    check("foul_fs", false_start, 1'b1);
    check("foul_busy", busy, 1'b0);
    check("foul_led", led_go, 1'b0);
    check("foul_digits", digits, 16'h0000);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (led_go) seen++;
    end
    check("foul_no_go", seen, 0);
    check("foul_hold", false_start, 1'b1);
`ifdef REACTION_BEST_EN
    check("foul_best", best_ms, to_bcd(best_m));
`endif

    press(1'b0, c);
    wait_until(c + 5);
    check("rearm_fs", false_start, 1'b0);
    check("rearm_busy", busy, 1'b1);
    g = go_edge(c);
    wait_go(g);
    wait_until(g + 4 * 9999 + 2);
    check("pre_ovf_digits", digits, 16'h9999);
    check("pre_ovf_flag", overflow, 1'b0);
    check("pre_ovf_busy", busy, 1'b1);
    wait_until(g + 40002);
    check("ovf_digits", digits, 16'h9999);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_busy", busy, 1'b0);
    check("ovf_led", led_go, 1'b0);
    press(1'b1, c);
    repeat (6) @(negedge clk);
    check("ovf_react_ign", digits, 16'h9999);
    check("ovf_sticky", overflow, 1'b1);
`ifdef REACTION_BEST_EN
    check("ovf_best", best_ms, to_bcd(best_m));
`endif

    press(1'b0, c);
    g = go_edge(c);
    wait_go(g);
    wait_until(g + 4 * $urandom_range(3, 20) + 1);
    check("pre_rst_led", led_go, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_digits", digits, 16'h0000);
    check("mid_rst_led", led_go, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_fs", false_start, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
`ifdef REACTION_BEST_EN
    check("mid_rst_best", best_ms, 16'h9999);
`endif
    best_m = 9999;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat ($urandom_range(0, 7)) @(negedge clk);

    run_trial(250, $urandom_range(1, 3), e);
    check("t250", digits, 16'h0250);
    run_trial(180, $urandom_range(1, 3), e);
    check("t180", digits, 16'h0180);
    run_trial(300, $urandom_range(1, 3), e);
    check("t300", digits, 16'h0300);
`ifdef REACTION_BEST_EN
    check("best_0180", best_ms, 16'h0180);
`endif
    press(1'b0, c);
    wait_until(c + 9);
    press(1'b1, c);
    wait_until(c + 5);
    check("foul2_fs", false_start, 1'b1);
`ifdef REACTION_BEST_EN
    check("foul2_best", best_ms, 16'h0180);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
